// File: rtl/pad_ctrl_sampler.sv
// Pad-ring controller: registers OEN/I/PEN drive, samples pad O through a 2-FF synchronizer,
// a glitch filter and sticky edge interrupts. Optional open-drain mode: PAD_CTRL_OPEN_DRAIN_EN.
module pad_ctrl_sampler #(
    parameter int NPADS  = 4,
    parameter int FILT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NPADS-1:0]  cfg_dir_i,
    input  logic [NPADS-1:0]  cfg_out_i,
    input  logic [NPADS-1:0]  cfg_pen_i,
    input  logic [FILT_W-1:0] cfg_filt_i,
    input  logic [NPADS-1:0]  cfg_irq_en_i,
    input  logic [NPADS-1:0]  cfg_irq_rise_i,
    input  logic [NPADS-1:0]  irq_clr_i,
`ifdef PAD_CTRL_OPEN_DRAIN_EN
    input  logic [NPADS-1:0]  cfg_od_i,
`endif
    output logic [NPADS-1:0]  in_o,
    output logic [NPADS-1:0]  irq_pending_o,
    output logic              irq_o,
    output logic [NPADS-1:0]  pad_oen_o,
    output logic [NPADS-1:0]  pad_out_o,
    output logic [NPADS-1:0]  pad_pen_o,
    input  logic [NPADS-1:0]  pad_in_i
);

    logic [NPADS-1:0] oen_q, oen_d, out_q, out_d, pen_q;
    logic [NPADS-1:0] s1_q, s2_q;
    logic [NPADS-1:0] filt_q, filt_d, filt_prev_q;
    logic [NPADS-1:0] pend_q, pend_d;
    logic [NPADS-1:0] rise_ev, fall_ev, sel_ev;
    logic [NPADS-1:0][FILT_W-1:0] cnt_q, cnt_d;

`ifdef PAD_CTRL_OPEN_DRAIN_EN
    // Open-drain pads only ever drive low; data 1 releases the pad.
    assign oen_d = (~cfg_dir_i & ~cfg_od_i) | (cfg_out_i & cfg_od_i);
    assign out_d = cfg_out_i & ~cfg_od_i;
`else
    assign oen_d = ~cfg_dir_i;
    assign out_d = cfg_out_i;
`endif

    // A disagreement must persist past the threshold before in_o follows; >= tolerates a lowered threshold.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < NPADS; i++) begin
            if (s2_q[i] != filt_q[i]) begin
                if (cnt_q[i] >= cfg_filt_i) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + FILT_W'(1);
                end
            end
        end
    end

    assign rise_ev = filt_q & ~filt_prev_q;
    assign fall_ev = ~filt_q & filt_prev_q;
    assign sel_ev  = (cfg_irq_rise_i & rise_ev) | (~cfg_irq_rise_i & fall_ev);
    assign pend_d  = (pend_q & ~irq_clr_i) | (cfg_irq_en_i & sel_ev);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oen_q       <= '1;
            out_q       <= '0;
            pen_q       <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
        end else begin
            oen_q       <= oen_d;
            out_q       <= out_d;
            pen_q       <= cfg_pen_i;
            s1_q        <= pad_in_i;
            s2_q        <= s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
        end
    end

    assign in_o          = filt_q;
    assign irq_pending_o = pend_q;
    assign irq_o         = |pend_q;
    assign pad_oen_o     = oen_q;
    assign pad_out_o     = out_q;
    assign pad_pen_o     = pen_q;

endmodule

// File: doc/pad_ctrl_sampler.md
Name: pad_ctrl_sampler

Overview:
- Core-side controller for an array of bidirectional functional pads.
- Registers the direction, output-data and pull-enable controls that drive each pad's OEN/I/PEN pins.
- Samples each pad's O pin through a 2-FF synchronizer and a programmable glitch filter.
- Raises per-pad edge interrupts with sticky pending bits. Sits between the GPIO/peripheral register file and the pad ring.

Parameters:
- NPADS, 4, number of pads handled.
- FILT_W, 4, width of the glitch-filter threshold and of each per-pad filter counter.

Ports:
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_dir_i  in  NPADS  1 = pad is output.
- cfg_out_i  in  NPADS  output data.
- cfg_pen_i  in  NPADS  pull enable.
- cfg_filt_i  in  FILT_W  filter threshold; 0 = no filtering beyond synchronizer.
- cfg_irq_en_i  in  NPADS  per-pad interrupt enable.
- cfg_irq_rise_i  in  NPADS  1 = rising edge, 0 = falling edge.
- irq_clr_i  in  NPADS  one-cycle clear pulse per pending bit.
- in_o  out  NPADS  filtered input value.
- irq_pending_o  out  NPADS  sticky pending bits.
- irq_o  out  1  OR of irq_pending_o.
- pad_oen_o  out  NPADS  to pad OEN; 1 = tristate.
- pad_out_o  out  NPADS  to pad I.
- pad_pen_o  out  NPADS  to pad PEN.
- pad_in_i  in  NPADS  from pad O; asynchronous.

Behaviour:
- Reset (asynchronous, rst_i=1) values:
  - pad_oen_o = all 1 (all pads tristate).
  - pad_out_o = 0, pad_pen_o = 0.
  - Synchronizer flops = 0, filter counters = 0, in_o = 0.
  - irq_pending_o = 0, irq_o = 0.
- Reset asserted mid-operation clears all state immediately. No partial edge is reported after release.
- Output path:
  - pad_oen_o <= ~cfg_dir_i, pad_out_o <= cfg_out_i, pad_pen_o <= cfg_pen_i.
  - 1 cycle latency, no combinational path from cfg to pad.
- Synchronizer: s1 <= pad_in_i, s2 <= s1.
- Filter, per pad, each cycle with filt = in_o bit and cnt = FILT_W-bit counter:
  - s2 == filt: cnt <= 0.
  - s2 != filt and cnt >= cfg_filt_i: filt <= s2, cnt <= 0.
  - s2 != filt otherwise: cnt <= cnt+1.
  - The >= comparison covers cfg_filt_i lowered mid-count; cnt never wraps.
- Latency from pad_in_i change (stable) to in_o change: 3 + cfg_filt_i cycles.
- A pulse shorter than cfg_filt_i+1 cycles at s2 never reaches in_o.
- Input path runs regardless of cfg_dir_i, so an output pad reads back its own level.
- Edge detect: uses filt_prev (filt delayed 1 cycle).
  - Rise event = filt & ~filt_prev.
  - Fall event = ~filt & filt_prev.
- Pending bit: pending <= (pending & ~irq_clr_i) | (cfg_irq_en_i & selected event).
  - A set and a clear in the same cycle leave the bit set (set wins).
  - Disabling cfg_irq_en_i does not clear existing pending bits.
- irq_o is combinational OR of the pending registers; it is glitch-free because it is driven only by registers.
- Event-to-pending latency: pending visible 1 cycle after the in_o change.

Optional Feature:
- Macro PAD_CTRL_OPEN_DRAIN_EN.
- Defined:
  - Adds input port cfg_od_i [NPADS].
  - For a pad with cfg_od_i=1: pad_out_o <= 0 and pad_oen_o <= cfg_out_i.
  - So the pad drives low for data 0 and tristates (external/pull high) for data 1, independent of cfg_dir_i.
  - Pads with cfg_od_i=0 behave as in the base behaviour.
- Undefined: the port is absent; all pads are push-pull as specified.

Test Plan:
- Reset/output path:
  - Stimulus: assert rst_i with cfg_dir_i=4'b1010, cfg_out_i=4'b1111. Release rst_i.
  - Required: pad_oen_o=4'b1111 during reset; pad_oen_o=4'b0101 and pad_out_o=4'b1111 exactly 1 cycle after release.
- Filter latency:
  - Stimulus: cfg_filt_i=3; pad_in_i[0] 0->1 held.
  - Required: in_o[0] rises exactly 6 cycles later. With cfg_filt_i=0, it rises 3 cycles later.
- Glitch rejection:
  - Stimulus: cfg_filt_i=3; pad_in_i[1] high for 3 cycles, then low.
  - Required: in_o[1] stays 0, irq_pending_o stays 0.
- Edge IRQ and clear:
  - Stimulus: cfg_irq_en_i[2]=1, cfg_irq_rise_i[2]=0; pad 2 goes 1->0. Then pulse irq_clr_i[2].
  - Required: irq_pending_o[2] and irq_o assert 1 cycle after in_o[2] falls; both deassert the cycle after irq_clr_i[2].
- Simultaneous set/clear:
  - Stimulus: irq_clr_i[3] pulsed in the same cycle a new rise event on pad 3 occurs.
  - Required: irq_pending_o[3] remains 1.
- Open drain (with PAD_CTRL_OPEN_DRAIN_EN):
  - Stimulus: cfg_od_i[0]=1; cfg_out_i[0] toggled 0->1.
  - Required: pad_out_o[0]=0 throughout; pad_oen_o[0] goes 0->1 one cycle after the toggle.
